bus_remap_pipe: RTL

//  Multi-channel, range-generic bus remapper with a small elastic FIFO.

---
 rtl/bus_remap_pipe.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bus_remap_pipe.sv
// -----------------------------------------------------------------------------
// bus_remap_pipe
//
// Purpose:
//   Multi-channel bus remapper followed by a small elastic FIFO. Each accepted
//   word carries CHANNELS buses of WIDTH bits; bus bits are declared
//   [LO+WIDTH-1:LO] (LO may be negative). At push time the word is transformed
//   according to in_mode (PASS, REVERSE, TIE, SWAP), and the transformed word
//   is stored. Queued words are emitted in strict FIFO order.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (flushes the FIFO)
//   in_valid   producer has a word on in_data
//   in_ready   FIFO can accept a word (depends on level only)
//   in_data    CHANNELS*WIDTH input word, channel c at [c*WIDTH +: WIDTH]
//   in_mode    0 PASS, 1 REVERSE, 2 TIE, 3 SWAP
//   const_val  tie-off value used in TIE mode
//   chan_mask  channels replaced by const_val in TIE mode
//   out_valid  FIFO head is valid
//   out_ready  consumer accepts the head
//   out_data   transformed head word, zero when the FIFO is empty
//   level      current FIFO occupancy
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. push = in_valid & in_ready, pop = out_valid & out_ready. A
// producer seeing in_ready low keeps in_valid and its data stable; in_ready
// never looks at out_ready, so a full FIFO refuses a push even while popping.
// -----------------------------------------------------------------------------
module bus_remap_pipe #(
    parameter int WIDTH    = 5,
    parameter int LO       = -2,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 2,
    parameter int LVLW     = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [1:0]                   in_mode,
    input  logic [WIDTH-1:0]             const_val,
    input  logic [CHANNELS-1:0]          chan_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*WIDTH-1:0]    out_data,
    output logic [LVLW-1:0]              level
);

    localparam int HI   = LO + WIDTH - 1;
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_REVERSE = 2'd1;
    localparam logic [1:0] MODE_TIE     = 2'd2;
    localparam logic [1:0] MODE_SWAP    = 2'd3;

    localparam logic [LVLW-1:0] LVL_FULL = LVLW'(DEPTH);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);

    logic [CHANNELS*WIDTH-1:0] xf_data;
    logic                      push;
    logic                      pop;

    logic [PTRW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0]           level_q,  level_d;

    logic [CHANNELS*WIDTH-1:0] mem_q [DEPTH];

    // Transform of the word currently on the input, using this cycle's
    // mode/const_val/chan_mask. Only the pushed result is stored, so later
    // changes of these inputs never reach queued words.
    always_comb begin
        xf_data = in_data;
        case (in_mode)
            MODE_PASS: begin
                xf_data = in_data;
            end
            MODE_REVERSE: begin
                // Declared bit LO+k takes declared bit HI-k. Physical bit
                // position of declared index i is (i - LO), so LO cancels and
                // this is a plain bit reversal within each channel.
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int k = 0; k < WIDTH; k++) begin
                        xf_data[c*WIDTH + ((LO + k) - LO)] = in_data[c*WIDTH + ((HI - k) - LO)];
                    end
                end
            end
            MODE_TIE: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    xf_data[c*WIDTH +: WIDTH] = chan_mask[c] ? const_val
                                                             : in_data[c*WIDTH +: WIDTH];
                end
            end
            MODE_SWAP: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    xf_data[c*WIDTH +: WIDTH] = in_data[(CHANNELS-1-c)*WIDTH +: WIDTH];
                end
            end
            default: begin
                xf_data = in_data;
            end
        endcase
    end

    assign in_ready = (level_q != LVL_FULL);
    assign out_valid = (level_q != '0);
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVLW'(1);
            2'b01:   level_d = level_q - LVLW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage holds no reset: entries are only visible through out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= xf_data;
        end
    end

    assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;

endmodule
